cordic_ci_sequencer: RTL and testbench
======================================

# cordic_ci_sequencer

Sequencer between the Nios II multi-cycle custom-instruction port and the iterative cosine CORDIC core. Accepts one single-precision operand per request and loads it into the core. Enables the core for exactly `ITERATIONS` rotation steps, then captures the core's fixed-point result and returns it with a one-cycle `done` pulse. Owns all core control, so the core never over-iterates and never exposes a partial result.

## Interface
- `ITERATIONS`, 10: rotation steps per request; must match the core's angle table depth.
- `CNT_W`, 4: iteration counter width; must satisfy 2^CNT_W > `ITERATIONS`.
- `clock` in 1: single clock, rising edge.
- `aclr` in 1: reset, asynchronous, active-high.
- `clk_en` in 1: global enable. When low, all state, counters and outputs hold.
- `start` in 1: request strobe. Sampled on enabled edges.
- `dataa` in 32: IEEE-754 single operand. Captured when `start` is accepted.
- `busy` out 1: high while a request is in flight.
- `done` out 1: result-valid pulse.
- `result` out 32: returned value. Holds until overwritten by the next completion.
- `core_load` out 1: drives the core's clear/load input. The core loads x, y, z from `core_dataa` on each edge while this is high.
- `core_en` out 1: drives the core's `clk_en`. One rotation per enabled edge.
- `core_dataa` out 32: operand to the core.
- `core_result` in 32: core x output, unsigned Q1.31 (0x80000000 = 1.0). Valid only after exactly `ITERATIONS` steps.

## Operation
- FSM states: IDLE, LOAD, ITER, DONE. All transitions occur only on edges where `clk_en`=1.
- **IDLE**
  - `start`=1 → capture `{1'b0, dataa[30:0]}` into the operand register and go to LOAD.
  - The sign bit is cleared because cos is even.
- **LOAD**
  - `core_load`=1 for this state.
  - Clear the iteration counter, then go to ITER.
- **ITER**
  - `core_en` = `clk_en`.
  - The counter increments on each enabled edge.
  - When counter = `ITERATIONS`-1 on an enabled edge, go to DONE.
- **DONE**
  - `core_en`=0; `core_result` is final.
  - On the enabled edge: `result` ← converted `core_result`, `done` ← 1, go to IDLE.
- `done` is registered and high for exactly one enabled cycle; it clears on the next enabled edge.
- `busy` = (state ≠ IDLE).
- `start` while `busy`=1 is ignored: no queueing, the operand is not overwritten, and no extra `done` is produced.
- `start` in the cycle where `done`=1 (state IDLE) is accepted normally.
- `core_dataa` = operand register, constant from acceptance until the next acceptance.
- `core_load` = `aclr` OR (state = LOAD). The core is cleared whenever the sequencer is reset.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - `busy`=0, `done`=0, `result`=0x00000000.
  - `core_en`=0, `core_dataa`=0x00000000, `core_load`=1 while `aclr` is asserted.
- Latency, with `clk_en` held high:
  - `start` sampled in cycle 0; LOAD in cycle 1.
  - `core_en` high in cycles 2..`ITERATIONS`+1 (exactly `ITERATIONS` cycles).
  - DONE in cycle `ITERATIONS`+2.
  - `done`/`result` in cycle `ITERATIONS`+3 (13 for the default).
  - `busy` is high in cycles 1..`ITERATIONS`+2.
- Throughput: one request per `ITERATIONS`+3 cycles (back-to-back `start` is allowed in the `done` cycle).
- `clk_en` low for N cycles at any point stretches latency by exactly N.
  - `core_en` is never high while `clk_en` is low.
  - The total count of `core_en`-high cycles stays `ITERATIONS`.
- `aclr` mid-request:
  - Immediate return to the reset values and abort.
  - No `done` for the aborted request.
  - The first `start` after release behaves as from IDLE.

## Configuration
- `CORDIC_SEQ_FLOAT_OUT_EN` defined: `result` is the IEEE-754 single of `core_result`/2^31.
  - 0 → 0x00000000.
  - Otherwise, with p = index of the leading one: sign 0, exponent field = 96+p.
  - Mantissa = the 23 bits below bit p, truncated, zero-filled when p<23.
  - Conversion is combinational ahead of the result register; latency is unchanged.
- Not defined: `result` = raw `core_result` (Q1.31). No conversion logic is built.

## Test plan
- **Basic:**
  - Stimulus: `dataa`=0x3F800000 with `clk_en`=1; the core stub returns 0x40000000 after 10 steps.
  - `core_dataa`=0x3F800000; `core_load` high in cycle 1 only.
  - `core_en` high in cycles 2–11; `done` in cycle 13.
  - `result`=0x40000000 (raw) or 0x3F000000 (float).
- **Conversion edges:**
  - 0x80000000 → 0x3F800000.
  - 0x00000000 → 0x00000000.
  - 0x00000001 → 0x30000000 (float mode).
- **Busy-ignore and sign:**
  - `dataa`=0xBF800000 gives `core_dataa`=0x3F800000.
  - A second `start` with 0x40000000 in cycle 5 leaves `core_dataa` unchanged; exactly one `done`, in cycle 13.
- **Stall:** `clk_en` low in cycles 6–8 → `core_en` low there, 10 `core_en`-high cycles total, `done` in cycle 16.
- **Reset abort:**
  - `aclr` in cycle 6 → `busy`, `done`, `core_en` 0 and `result` 0 immediately; `core_load` high during reset; no `done`.
  - After release, `start` gives `done` 13 cycles later.
- **Back-to-back:** `start` in cycle 0 and again in cycle 13 → `done` in cycles 13 and 26, each `result` matching its operand.

Source files
------------

// File: rtl/cordic_ci_if.sv
// Custom-instruction side of the CORDIC sequencer.
// Master drives request/enable, slave returns status and result.
interface cordic_ci_if;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output clk_en,
    output start,
    output dataa,
    input  busy,
    input  done,
    input  result
  );

  modport slave (
    input  clk_en,
    input  start,
    input  dataa,
    output busy,
    output done,
    output result
  );
endinterface

// File: rtl/cordic_ci_sequencer.sv
// Custom-instruction sequencer for the iterative cosine CORDIC core.
// Define CORDIC_SEQ_FLOAT_OUT_EN to return IEEE-754 single instead of Q1.31.
module cordic_ci_sequencer #(
  parameter int ITERATIONS = 10,
  parameter int CNT_W      = 4
) (
  input  logic        clock,
  input  logic        aclr,
  cordic_ci_if.slave  ci,
  output logic        core_load,
  output logic        core_en,
  output logic [31:0] core_dataa,
  input  logic [31:0] core_result
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ITER,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(ITERATIONS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      operand;
  logic [31:0]      result_q;
  logic             done_q;
  logic [31:0]      result_d;

`ifdef CORDIC_SEQ_FLOAT_OUT_EN
  // Q1.31 to float: value = q / 2^31, so exponent = 127 + p - 31.
  function automatic logic [31:0] q131_to_float(
    input logic [31:0] q
  );
    logic [4:0]  p;
    logic [7:0]  ex;
    logic [22:0] man;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      if (q[i]) p = 5'(i);
    end
    ex  = 8'd96 + {3'b000, p};
    man = 23'((q << (6'd32 - {1'b0, p})) >> 9);
    if (q == 32'd0) begin
      q131_to_float = 32'd0;
    end else begin
      q131_to_float = {1'b0, ex, man};
    end
  endfunction

  assign result_d = q131_to_float(core_result);
`else
  assign result_d = core_result;
`endif

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state    <= IDLE;
      cnt      <= '0;
      operand  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (ci.clk_en) begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          // cos is even, so the sign never reaches the core
          if (ci.start) begin
            operand <= ci.dataa & 32'h7FFF_FFFF;
            state   <= LOAD;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= ITER;
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          result_q <= result_d;
          done_q   <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ci.busy    = (state != IDLE);
  assign ci.done    = done_q;
  assign ci.result  = result_q;
  assign core_dataa = operand;
  assign core_load  = aclr | (state == LOAD);
  assign core_en    = (state == ITER) & ci.clk_en;

endmodule

// File: tb/tb_cordic_ci_sequencer.sv
// Scoreboard bench for cordic_ci_sequencer with a counting core stub.
// Expected values follow CORDIC_SEQ_FLOAT_OUT_EN when defined.
module tb_cordic_ci_sequencer;

`ifdef CORDIC_SEQ_FLOAT_OUT_EN
  localparam logic [31:0] EXP_HALF = 32'h3F00_0000;
  localparam logic [31:0] EXP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] EXP_LSB  = 32'h3000_0000;
`else
  localparam logic [31:0] EXP_HALF = 32'h4000_0000;
  localparam logic [31:0] EXP_ONE  = 32'h8000_0000;
  localparam logic [31:0] EXP_LSB  = 32'h0000_0001;
`endif

  logic        clock = 1'b0;
  logic        aclr;
  logic        core_load;
  logic        core_en;
  logic [31:0] core_dataa;
  logic [31:0] core_result;

  cordic_ci_if ci ();

  cordic_ci_sequencer #(
    .ITERATIONS (10),
    .CNT_W      (4)
  ) dut (
    .clock       (clock),
    .aclr        (aclr),
    .ci          (ci),
    .core_load   (core_load),
    .core_en     (core_en),
    .core_dataa  (core_dataa),
    .core_result (core_result)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // core stub: final value only after exactly 10 steps
  logic [31:0] stub_next = '0;
  logic [31:0] core_x    = '0;
  int          steps     = 0;
  always @(posedge clock) begin
    if (core_load) begin
      core_x <= stub_next;
      steps  <= 0;
    end else if (core_en) begin
      steps <= steps + 1;
    end
  end
  assign core_result = (steps == 10) ? core_x : ~core_x;

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   en_n   = 0;
  int   load_n = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (aclr) begin
      en_n   = 0;
      load_n = 0;
    end else begin
      if (core_en && !ci.clk_en)
        check("core_en_gated", {31'b0, core_en}, 32'd0);
      if (ci.done) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done at %0d want none",
                   cyc);
        end else begin
          e = sb.pop_front();
          check("result", ci.result, e.res);
          check("done_cycle", 32'(cyc), 32'(e.at));
          check("en_steps", 32'(en_n), 32'd10);
          check("load_cycles", 32'(load_n), 32'd1);
        end
        en_n   = 0;
        load_n = 0;
      end
      if (core_en) en_n++;
      if (core_load) load_n++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(logic [31:0] a, logic [31:0] stub,
                       logic [31:0] exp_res, int lat);
    exp_t e;
    stub_next = stub;
    ci.start  = 1'b1;
    ci.dataa  = a;
    e.res     = exp_res;
    e.at      = cyc + lat;
    sb.push_back(e);
    tick();
    ci.start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending want 0",
               sb.size());
      sb.delete();
    end
    tick();
    tick();
  endtask

  initial begin
    aclr      = 1'b1;
    ci.clk_en = 1'b1;
    ci.start  = 1'b0;
    ci.dataa  = '0;
    #2;
    check("rst_busy", {31'b0, ci.busy}, 32'd0);
    check("rst_done", {31'b0, ci.done}, 32'd0);
    check("rst_result", ci.result, 32'd0);
    check("rst_core_en", {31'b0, core_en}, 32'd0);
    check("rst_core_dataa", core_dataa, 32'd0);
    check("rst_core_load", {31'b0, core_load}, 32'd1);
    tick();
    aclr = 1'b0;
    tick();

    // basic
    issue(32'h3F80_0000, 32'h4000_0000, EXP_HALF, 13);
    check("basic_core_dataa", core_dataa, 32'h3F80_0000);
    check("basic_load_c1", {31'b0, core_load}, 32'd1);
    check("basic_busy_c1", {31'b0, ci.busy}, 32'd1);
    tick();
    check("basic_load_c2", {31'b0, core_load}, 32'd0);
    check("basic_en_c2", {31'b0, core_en}, 32'd1);
    drain();

    // conversion edges
    issue(32'h3F80_0000, 32'h8000_0000, EXP_ONE, 13);
    drain();
    issue(32'h3F80_0000, 32'h0000_0000, 32'h0, 13);
    drain();
    issue(32'h3F80_0000, 32'h0000_0001, EXP_LSB, 13);
    drain();

    // busy-ignore and sign strip
    issue(32'hBF80_0000, 32'h4000_0000, EXP_HALF, 13);
    check("sign_core_dataa", core_dataa, 32'h3F80_0000);
    repeat (4) tick();
    stub_next = 32'h0000_0001;
    ci.start  = 1'b1;
    ci.dataa  = 32'h4000_0000;
    tick();
    ci.start = 1'b0;
    check("ignore_core_dataa", core_dataa, 32'h3F80_0000);
    drain();
    repeat (4) tick();
    check("ignore_idle_busy", {31'b0, ci.busy}, 32'd0);

    // stall cycles 6..8
    issue(32'h3F80_0000, 32'h8000_0000, EXP_ONE, 16);
    repeat (5) tick();
    ci.clk_en = 1'b0;
    repeat (3) tick();
    ci.clk_en = 1'b1;
    drain();

    // reset abort in cycle 6
    stub_next = 32'h4000_0000;
    ci.start  = 1'b1;
    ci.dataa  = 32'h3F80_0000;
    tick();
    ci.start = 1'b0;
    repeat (5) tick();
    aclr = 1'b1;
    #1;
    check("abort_busy", {31'b0, ci.busy}, 32'd0);
    check("abort_done", {31'b0, ci.done}, 32'd0);
    check("abort_core_en", {31'b0, core_en}, 32'd0);
    check("abort_result", ci.result, 32'd0);
    check("abort_core_load", {31'b0, core_load}, 32'd1);
    tick();
    aclr = 1'b0;
    repeat (20) tick();
    issue(32'h3F80_0000, 32'h4000_0000, EXP_HALF, 13);
    drain();

    // back-to-back, second start in the done cycle
    issue(32'h3F80_0000, 32'h4000_0000, EXP_HALF, 13);
    repeat (12) tick();
    issue(32'h3F00_0000, 32'h0000_0001, EXP_LSB, 13);
    check("b2b_core_dataa", core_dataa, 32'h3F00_0000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
